// File: rtl/seq_bit_tx.sv
// seq_bit_tx: parallel word in over load/ready, MSB-first serial out on x_out, then GAP idle zeros.
// Latency: data_in[WIDTH-1] appears on x_out the cycle after the accepting edge; one bit per clock.
// Backpressure: ready is low while shifting (except last bit when GAP=0) and in GAP; loads then are dropped.
module seq_bit_tx #(
  parameter int WIDTH = 8,
  parameter int GAP   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  input  logic             abort,
  output logic             ready,
  output logic             x_out,
  output logic             frame_done,
  output logic [1:0]       curr_state,
  output logic [3:0]       bit_cnt,
  output logic [7:0]       words_sent
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_GAP   = 2'b10,
    S_BAD   = 2'b11
  } state_t;

  localparam logic [3:0] LAST_BIT = 4'(WIDTH - 1);
  localparam logic [3:0] GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [3:0]       r_bit_cnt;
  logic [3:0]       r_gap_cnt;
  logic [7:0]       r_words;

  state_t           w_state_n;
  logic [WIDTH-1:0] w_shreg_n;
  logic [3:0]       w_bit_cnt_n;
  logic [3:0]       w_gap_cnt_n;
  logic [7:0]       w_words_n;
  logic             w_last_bit;

  assign w_last_bit = (r_state == S_SHIFT) && (r_bit_cnt == LAST_BIT);

  // Outputs decode only registered state; no input-to-output path.
  assign x_out      = (r_state == S_SHIFT) ? r_shreg[WIDTH-1] : 1'b0;
  assign frame_done = w_last_bit;
  assign ready      = (r_state == S_IDLE) || (w_last_bit && (GAP == 0));
  assign curr_state = r_state;
  assign bit_cnt    = r_bit_cnt;
  assign words_sent = r_words;

  // Next-state logic: abort beats load, load beats normal sequencing.
  always_comb begin
    w_state_n   = r_state;
    w_shreg_n   = r_shreg;
    w_bit_cnt_n = r_bit_cnt;
    w_gap_cnt_n = r_gap_cnt;
    w_words_n   = r_words;
    case (r_state)
      S_IDLE: begin
        // An abort arriving while idle also swallows a simultaneous load.
        if (!abort && load) begin
          w_shreg_n   = data_in;
          w_bit_cnt_n = 4'd0;
          w_state_n   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (abort) begin
          w_state_n   = S_IDLE;
          w_shreg_n   = '0;
          w_bit_cnt_n = 4'd0;
        end else if (r_bit_cnt == LAST_BIT) begin
          w_words_n   = r_words + 8'd1;
          w_bit_cnt_n = 4'd0;
          if (GAP > 0) begin
            w_state_n   = S_GAP;
            w_gap_cnt_n = 4'd0;
            w_shreg_n   = '0;
          end else if (load) begin
            // Back-to-back reload: the next word follows with no idle bit.
            w_shreg_n = data_in;
            w_state_n = S_SHIFT;
          end else begin
            w_state_n = S_IDLE;
            w_shreg_n = '0;
          end
        end else begin
          w_shreg_n   = {r_shreg[WIDTH-2:0], 1'b0};
          w_bit_cnt_n = r_bit_cnt + 4'd1;
        end
      end
      S_GAP: begin
        if (abort || (r_gap_cnt == GAP_LAST)) begin
          w_state_n   = S_IDLE;
          w_gap_cnt_n = 4'd0;
        end else begin
          w_gap_cnt_n = r_gap_cnt + 4'd1;
        end
      end
      default: begin
        // Unreachable encoding: recover to a clean idle.
        w_state_n   = S_IDLE;
        w_shreg_n   = '0;
        w_bit_cnt_n = 4'd0;
        w_gap_cnt_n = 4'd0;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_shreg   <= '0;
      r_bit_cnt <= 4'd0;
      r_gap_cnt <= 4'd0;
      r_words   <= 8'd0;
    end else begin
      r_state   <= w_state_n;
      r_shreg   <= w_shreg_n;
      r_bit_cnt <= w_bit_cnt_n;
      r_gap_cnt <= w_gap_cnt_n;
      r_words   <= w_words_n;
    end
  end

endmodule

// File: tb/tb_seq_bit_tx.sv
// Bench for seq_bit_tx: one instance with GAP=2, one with GAP=0 for back-to-back words.
// Directed stimulus, sampled 1 ns after each rising edge.
// Expected values are hand-computed constants.
module tb_seq_bit_tx;

  logic       clk = 1'b0;
  logic       reset;

  logic [7:0] d_a, d_b;
  logic       ld_a, ld_b, ab_a, ab_b;
  logic       rdy_a, rdy_b, x_a, x_b, fd_a, fd_b;
  logic [1:0] st_a, st_b;
  logic [3:0] bc_a, bc_b;
  logic [7:0] ws_a, ws_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  seq_bit_tx #(.WIDTH(8), .GAP(2)) dut_a (
    .clk(clk), .reset(reset), .data_in(d_a), .load(ld_a), .abort(ab_a),
    .ready(rdy_a), .x_out(x_a), .frame_done(fd_a), .curr_state(st_a),
    .bit_cnt(bc_a), .words_sent(ws_a)
  );

  seq_bit_tx #(.WIDTH(8), .GAP(0)) dut_b (
    .clk(clk), .reset(reset), .data_in(d_b), .load(ld_b), .abort(ab_b),
    .ready(rdy_b), .x_out(x_b), .frame_done(fd_b), .curr_state(st_b),
    .bit_cnt(bc_b), .words_sent(ws_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Send one word on dut_a, checking every bit and the gap. A stray load of
  // 8'hFF is injected during bit index inj (inj<0 for none). det counts
  // overlapping "1001" matches seen on x_out across the word and gap.
  task automatic run_word(input logic [7:0] w, input int inj, output int det);
    logic [3:0] h;
    h   = 4'd0;
    det = 0;
    d_a = w; ld_a = 1'b1;
    tick();
    ld_a = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("word_x", {31'd0, x_a}, {31'd0, w[7-k]});
      chk("word_fd", {31'd0, fd_a}, {31'd0, (k == 7)});
      chk("word_bc", {28'd0, bc_a}, k);
      chk("word_rdy", {31'd0, rdy_a}, 0);
      h = {h[2:0], x_a};
      if (h == 4'b1001) det++;
      if (k == inj) begin d_a = 8'hFF; ld_a = 1'b1; end
      tick();
      if (k == inj) ld_a = 1'b0;
    end
    for (int g = 0; g < 2; g++) begin
      chk("gap_x", {31'd0, x_a}, 0);
      chk("gap_st", {30'd0, st_a}, 2);
      chk("gap_rdy", {31'd0, rdy_a}, 0);
      h = {h[2:0], x_a};
      if (h == 4'b1001) det++;
      tick();
    end
    chk("post_rdy", {31'd0, rdy_a}, 1);
    chk("post_st", {30'd0, st_a}, 0);
  endtask

  logic [15:0] b2b;
  int det;

  initial begin
    reset = 1'b0;
    d_a = 8'h00; ld_a = 1'b0; ab_a = 1'b0;
    d_b = 8'h00; ld_b = 1'b0; ab_b = 1'b0;
    #2;
    chk("rst_x", {31'd0, x_a}, 0);
    chk("rst_rdy", {31'd0, rdy_a}, 1);
    chk("rst_st", {30'd0, st_a}, 0);
    chk("rst_ws", {24'd0, ws_a}, 0);
    chk("rst_fd", {31'd0, fd_a}, 0);
    #13 reset = 1'b1;
    #1;

    // Idle for 10 cycles with no load.
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_x", {31'd0, x_a}, 0);
      chk("idle_rdy", {31'd0, rdy_a}, 1);
      chk("idle_st", {30'd0, st_a}, 0);
      chk("idle_ws", {24'd0, ws_a}, 0);
    end

    // Single word 1001_0010: "1001" matches end at bits 3 and 6.
    run_word(8'b1001_0010, -1, det);
    chk("det_1001", det, 2);
    chk("ws_one", {24'd0, ws_a}, 1);

    // Load of 8'hFF during bit 3 must be ignored.
    run_word(8'h5A, 3, det);
    chk("ws_ignored", {24'd0, ws_a}, 2);

    // Back-to-back on GAP=0 instance: A5 then 3C, 16 contiguous bits.
    b2b = 16'hA53C;
    d_b = 8'hA5; ld_b = 1'b1;
    tick();
    ld_b = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk("b2b_x", {31'd0, x_b}, {31'd0, b2b[15-k]});
      if (k == 7) begin
        chk("b2b_rdy", {31'd0, rdy_b}, 1);
        d_b = 8'h3C; ld_b = 1'b1;
      end
      tick();
      if (k == 7) ld_b = 1'b0;
    end
    chk("b2b_st", {30'd0, st_b}, 0);
    chk("b2b_x_idle", {31'd0, x_b}, 0);
    chk("b2b_ws", {24'd0, ws_b}, 2);

    // Abort on bit 5 of 8'hF0.
    d_a = 8'hF0; ld_a = 1'b1;
    tick();
    ld_a = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("abt_bc", {28'd0, bc_a}, 5);
    chk("abt_x_pre", {31'd0, x_a}, 0);
    ab_a = 1'b1;
    tick();
    ab_a = 1'b0;
    chk("abt_st", {30'd0, st_a}, 0);
    chk("abt_x", {31'd0, x_a}, 0);
    chk("abt_bc0", {28'd0, bc_a}, 0);
    chk("abt_ws", {24'd0, ws_a}, 2);
    run_word(8'h81, -1, det);
    chk("abt_ws_after", {24'd0, ws_a}, 3);

    // Abort together with load in IDLE: load is dropped.
    d_a = 8'hFF; ld_a = 1'b1; ab_a = 1'b1;
    tick();
    ld_a = 1'b0; ab_a = 1'b0;
    chk("abt_idle_st", {30'd0, st_a}, 0);

    // Async reset mid-word, between edges.
    d_a = 8'hFF; ld_a = 1'b1;
    tick();
    ld_a = 1'b0;
    tick();
    chk("ar_pre_x", {31'd0, x_a}, 1);
    #2 reset = 1'b0;
    #1;
    chk("ar_x", {31'd0, x_a}, 0);
    chk("ar_st", {30'd0, st_a}, 0);
    chk("ar_ws", {24'd0, ws_a}, 0);
    #1 reset = 1'b1;
    tick();

    // 256 words: counter reaches 255 then wraps to 0.
    for (int n = 0; n < 256; n++) begin
      d_a = n[7:0]; ld_a = 1'b1;
      tick();
      ld_a = 1'b0;
      repeat (10) tick();
      if (n == 254) chk("wrap_255", {24'd0, ws_a}, 255);
    end
    chk("wrap_0", {24'd0, ws_a}, 0);
    chk("wrap_rdy", {31'd0, rdy_a}, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_bit_tx.md
Name: seq_bit_tx

Overview:
- Serial pattern transmitter: accepts a parallel word over a load/ready handshake and drives it MSB-first onto the 1-bit serial line `x_out`, one bit per clock.
- It is the source end of the serial bit-stream interface our sequence detectors consume. Its `x_out` connects directly to a detector's `x` input, so detector benches and board demos get deterministic, repeatable streams.
- After each word it inserts a fixed run of idle zero bits, then returns to idle.

Parameters:
- WIDTH, 8, bits per word; legal range 2..16.
- GAP, 2, idle zero bits driven after each word; legal range 0..15.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- data_in  input  WIDTH  word to transmit; sampled only on an accepted load.
- load  input  1  load request; accepted on a rising edge only when ready=1.
- abort  input  1  synchronous abort of the word or gap in progress.
- ready  output  1  block can accept a load this cycle.
- x_out  output  1  serial data line.
- frame_done  output  1  high during the cycle the last data bit is on x_out.
- curr_state  output  2  FSM state: 00 IDLE, 01 SHIFT, 10 GAP.
- bit_cnt  output  4  index of the bit currently on x_out, 0..WIDTH-1; 0 outside SHIFT.
- words_sent  output  8  count of fully transmitted words.

Behaviour:
- Reset (reset=0, asynchronous, no clock needed): takes effect immediately and holds while reset=0.
  - curr_state=00, x_out=0, ready=1, frame_done=0, bit_cnt=0, words_sent=0, shift register=0, gap counter=0.
  - Reset asserted mid-word or mid-gap discards the word; no count increment.
- Outputs x_out, ready, frame_done are decoded only from registered state. No combinational path from load/abort/data_in to any output.
  - x_out = shreg[WIDTH-1] when in SHIFT, else 0.
  - ready = 1 in IDLE, or in SHIFT with bit_cnt=WIDTH-1 and GAP=0; else 0.
- Edge priority: reset > abort > load > normal sequencing.
- IDLE: x_out=0.
  - On an edge with load=1: shreg<=data_in, bit_cnt<=0, go SHIFT.
  - Latency: data_in[WIDTH-1] appears on x_out in the cycle right after the accepting edge.
- SHIFT: each edge shifts shreg left by 1 (zero fill) and increments bit_cnt.
  - Word bit WIDTH-1-k is on x_out while bit_cnt=k.
  - At the edge where bit_cnt=WIDTH-1 the word completes and words_sent increments. Then:
    - GAP>0: go GAP with gap counter=0.
    - GAP=0 and load=1: back-to-back reload (shreg<=data_in, bit_cnt<=0, stay SHIFT). Consecutive words have no idle bit between them.
    - GAP=0 and load=0: go IDLE.
- GAP: x_out=0 for exactly GAP cycles, then IDLE. load is ignored in GAP (ready=0).
- abort=1 in SHIFT or GAP:
  - Next edge goes to IDLE with x_out=0 and bit_cnt=0.
  - words_sent does not increment, even if the abort lands on the last bit.
  - abort in IDLE has no effect; load on the same edge is ignored.
- load while ready=0 is ignored and not queued.
- words_sent wraps 255 -> 0.
- Total word period when loads arrive as soon as ready: WIDTH+GAP+1 cycles for GAP>0; WIDTH cycles for GAP=0 back-to-back.
- curr_state 11 is unreachable; if entered, the next edge goes to IDLE.

Test Plan:
- Reset then idle: reset=0 for 15 ns, release; no load -> x_out=0, ready=1, curr_state=00, words_sent=0 for 10 cycles.
- Single word, WIDTH=8, GAP=2, data_in=8'b1001_0010, one-cycle load -> x_out sequence 1,0,0,1,0,0,1,0, then 0,0 in GAP.
  - frame_done high only on the 8th bit; ready back to 1 after 10 cycles; words_sent=1.
  - Feeding x_out to a "1001"-style detector yields its expected detection pulses.
- Ignored load: assert load during SHIFT bit 3 with data_in=8'hFF -> stream unchanged, no extra word, words_sent unchanged.
- Back-to-back, GAP=0: words 8'hA5 then 8'h3C, second load held on the last bit of the first -> 16 contiguous bits 10100101 00111100, words_sent=2.
- Abort: abort on bit_cnt=5 of 8'hF0 -> next cycle curr_state=00 and x_out=0; words_sent unchanged. A fresh load of 8'h81 transmits correctly.
- Async reset mid-word plus wrap: pulse reset low between clock edges during SHIFT -> x_out=0 and curr_state=00 before the next edge. Separately, send 256 words -> words_sent returns to 0.
